ir_key_decoder: RTL
===================

# ir_key_decoder

Parametrised IR remote receiver for the game controller path. It measures pulse-distance frames (leader, gap, CODE_W data bits) on the demodulated `irda` line and latches the received code. It maps the code onto the five game keys and raises a registered valid/rdy handshake. While idle it runs the 2-bit colour counter that the game logic uses as its random seed.

## Interface
- TICK_DIV, 50: clk cycles per measurement tick (50 gives 1 µs at 50 MHz); minimum 1
- CNT_W, 14: run-length counter width; must hold TIMEOUT
- CODE_W, 8: data bits per frame, MSB first
- LEAD_MIN, 8000: minimum leader low time, in ticks
- GAP_MIN, 3500: minimum post-leader high time for a data frame, in ticks
- REP_MIN, 1800: minimum post-leader high time for a repeat frame, in ticks
- BIT_THRESH, 1000: space ≥ BIT_THRESH ticks decodes as 1, otherwise 0
- TIMEOUT, 12000: maximum length of any single low or high run inside a frame, in ticks
- RDY_CYC, 4: clk cycles that rdy stays high per frame (minimum 1)
- KEY_BLUE / KEY_YELLOW / KEY_GREEN / KEY_RED / KEY_POWER, 8'h04 / 8'h06 / 8'h02 / 8'h03 / 8'h01: key codes
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- irda  in  1  IR receiver output, idle high, asynchronous
- code  out  CODE_W  last decoded code
- key  out  5  one-hot {power, red, green, yellow, blue}; 0 if code is unmapped
- valid  out  1  one-clk pulse for each accepted frame
- rdy  out  1  high for RDY_CYC clk, starting with valid
- err  out  1  one-clk pulse for each aborted frame
- color  out  2  free-running seed

## Operation
- `irda` is synchronised through two flops. An edge is detected by comparing the synchronised value with its previous value.
- The prescaler divides clk by TICK_DIV and runs freely. The run counter clears on every detected edge, increments on each tick, and saturates at TIMEOUT.
- States and transitions:
  - IDLE: color increments every clk and wraps 3→0. A falling edge moves to LEAD.
  - LEAD: on a rising edge, go to GAP if count ≥ LEAD_MIN, otherwise return to IDLE silently as a glitch.
  - GAP, on a falling edge:
    - count ≥ GAP_MIN: go to MARK and clear the bit index.
    - REP_MIN ≤ count < GAP_MIN: go to REPEAT (macro only).
    - otherwise: go to ERR.
  - MARK: a rising edge moves to SPACE.
  - SPACE: on a falling edge, shift in bit = (count ≥ BIT_THRESH). Then go to DONE if index = CODE_W-1, otherwise increment the index and go to MARK.
  - DONE (1 clk): load code from the shift register, look up key, pulse valid, load the rdy counter, then go to HOLD.
  - HOLD: `irda` is ignored. Return to IDLE when the rdy counter expires.
  - ERR (1 clk): pulse err, leave code and key unchanged, go to IDLE.
- In LEAD, GAP, MARK and SPACE, a saturated count moves to ERR. If an edge and saturation occur in the same clk, the edge wins.
- color is frozen in every state except IDLE.
- Key lookup is an exact CODE_W-bit compare. At most one key bit is set. If two KEY_* parameters are equal, priority is blue > yellow > green > red > power.
- Reset values:
  - state = IDLE
  - code = 0, key = 0, color = 0
  - valid = 0, rdy = 0, err = 0
  - prescaler = 0, run counter = 0, stored-code flag = 0
- Reset asserted mid-frame discards the partial code immediately.

## Timing
- Latency: a pin edge reaches edge detect 2 clk later. valid, rdy, code and key update on the next clk edge, 3 clk after the pin edge of the final mark.
- rdy is high for exactly RDY_CYC clk and then low for at least 1 clk before the next valid.
- A frame arriving during HOLD is lost; its leader is not seen until IDLE.
- Run-length quantisation is ±1 tick. Thresholds are inclusive as written above.

## Configuration
- IR_REPEAT_EN defined:
  - GAP with REP_MIN ≤ count < GAP_MIN goes to REPEAT, which waits for the rising edge of the following mark.
  - If the stored-code flag is set, REPEAT behaves as DONE with the last code: valid, rdy and key are reissued.
  - If the flag is clear, REPEAT goes to ERR.
  - The flag is set on every DONE.
- IR_REPEAT_EN undefined: REPEAT and the stored-code flag are absent, and every gap < GAP_MIN goes to ERR.

## Test plan
Bench parameters: TICK_DIV=1, CODE_W=8, LEAD_MIN=16, GAP_MIN=8, REP_MIN=4, BIT_THRESH=4, TIMEOUT=40, RDY_CYC=4, KEY_* at their defaults.

- Send a frame for code 8'h04 (leader 20 low, gap 10 high, then marks of 2 low with spaces of 2 or 6 high, then a stop mark) -> valid pulses once, code=8'h04, key=5'b00001, rdy is high for 4 clk starting with valid, err=0.
- Send a frame for code 8'h55 -> valid pulses, code=8'h55, key=0.
- Send a 10-tick leader -> no valid and no err; colour resumes counting.
- Send a valid header, then hold `irda` low for 45 ticks mid-bit -> err pulses once, code keeps its previous value, state returns to IDLE.
- With IR_REPEAT_EN, send a frame for 8'h03, then a repeat frame (leader 20, gap 5, mark 2) -> second valid pulses with code=8'h03 and key=5'b01000. Without the macro, the same stimulus gives an err pulse.
- Assert rst in the middle of the data bits -> all outputs are 0 immediately. A following clean 8'h01 frame decodes to key=5'b10000.

Source files
------------

// File: rtl/ir_key_decoder.sv
// Pulse-distance IR receiver: measures leader/gap/bit runs on irda, latches the code,
// maps it to five game keys and drives valid/rdy/err. Optional IR_REPEAT_EN adds repeat frames.
module ir_key_decoder #(
  parameter int TICK_DIV   = 50,
  parameter int CNT_W      = 14,
  parameter int CODE_W     = 8,
  parameter int LEAD_MIN   = 8000,
  parameter int GAP_MIN    = 3500,
  parameter int REP_MIN    = 1800,
  parameter int BIT_THRESH = 1000,
  parameter int TIMEOUT    = 12000,
  parameter int RDY_CYC    = 4,
  parameter logic [CODE_W-1:0] KEY_BLUE   = CODE_W'('h04),
  parameter logic [CODE_W-1:0] KEY_YELLOW = CODE_W'('h06),
  parameter logic [CODE_W-1:0] KEY_GREEN  = CODE_W'('h02),
  parameter logic [CODE_W-1:0] KEY_RED    = CODE_W'('h03),
  parameter logic [CODE_W-1:0] KEY_POWER  = CODE_W'('h01)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irda,
  output logic [CODE_W-1:0] code,
  output logic [4:0]        key,
  output logic              valid,
  output logic              rdy,
  output logic              err,
  output logic [1:0]        color
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int RC_W  = $clog2(RDY_CYC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_W - 1);
  localparam logic [RC_W-1:0]  RDY_LOAD = RC_W'(RDY_CYC - 1);
  localparam logic [CNT_W-1:0] LEAD_M   = CNT_W'(LEAD_MIN);
  localparam logic [CNT_W-1:0] GAP_M    = CNT_W'(GAP_MIN);
  localparam logic [CNT_W-1:0] THRESH_M = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] TMO_M    = CNT_W'(TIMEOUT);
`ifdef IR_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_M    = CNT_W'(REP_MIN);
`endif

  // Packed key table, bit order of key: {power, red, green, yellow, blue}
  localparam logic [5*CODE_W-1:0] KEY_TAB = {KEY_POWER, KEY_RED, KEY_GREEN, KEY_YELLOW, KEY_BLUE};

  typedef enum logic [3:0] {
    IDLE, LEAD, GAP, MARK, SPACE, DONE, HOLD, ERR
`ifdef IR_REPEAT_EN
    , REPEAT
`endif
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]        sync_reg;
  logic              irda_d_reg;
  logic [PRE_W-1:0]  pre_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CODE_W-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [4:0]        key_reg, key_next;
  logic              valid_reg, valid_next;
  logic              rdy_reg, rdy_next;
  logic              err_reg, err_next;
  logic [RC_W-1:0]   rdy_cnt_reg, rdy_cnt_next;
  logic [1:0]        color_reg, color_next;
`ifdef IR_REPEAT_EN
  logic              flag_reg, flag_next;
`endif

  logic              irda_s, edge_det, rise, fall, tick, sat, bit_in;
  logic [CODE_W-1:0] shift_in, lookup_code;
  logic [4:0]        key_hit, key_sel;

  assign irda_s   = sync_reg[1];
  assign edge_det = irda_s ^ irda_d_reg;
  assign rise     = edge_det & irda_s;
  assign fall     = edge_det & ~irda_s;
  assign tick     = (pre_reg == PRE_LAST);
  assign sat      = (cnt_reg == TMO_M);
  assign bit_in   = (cnt_reg >= THRESH_M);
  assign shift_in = {shift_reg[CODE_W-2:0], bit_in};

`ifdef IR_REPEAT_EN
  assign lookup_code = (state_reg == REPEAT) ? code_reg : shift_in;
`else
  assign lookup_code = shift_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_key
      assign key_hit[gi] = (lookup_code == KEY_TAB[gi*CODE_W +: CODE_W]);
    end
  endgenerate

  // Keep only the lowest matching bit so blue wins over yellow, and so on
  assign key_sel = key_hit & (~key_hit + 5'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg   <= 2'b11;
      irda_d_reg <= 1'b1;
      pre_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      sync_reg   <= {sync_reg[0], irda};
      irda_d_reg <= irda_s;
      pre_reg    <= tick ? '0 : pre_reg + PRE_W'(1);
      if (edge_det)
        cnt_reg <= '0;
      else if (tick && !sat)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      idx_reg     <= '0;
      code_reg    <= '0;
      key_reg     <= '0;
      valid_reg   <= 1'b0;
      rdy_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rdy_cnt_reg <= '0;
      color_reg   <= '0;
`ifdef IR_REPEAT_EN
      flag_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      code_reg    <= code_next;
      key_reg     <= key_next;
      valid_reg   <= valid_next;
      rdy_reg     <= rdy_next;
      err_reg     <= err_next;
      rdy_cnt_reg <= rdy_cnt_next;
      color_reg   <= color_next;
`ifdef IR_REPEAT_EN
      flag_reg    <= flag_next;
`endif
    end
  end

  // Outputs are computed on the transition into DONE/ERR so they appear with the state change
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    idx_next     = idx_reg;
    code_next    = code_reg;
    key_next     = key_reg;
    valid_next   = 1'b0;
    rdy_next     = rdy_reg;
    rdy_cnt_next = rdy_cnt_reg;
    color_next   = color_reg;
    err_next     = 1'b0;
`ifdef IR_REPEAT_EN
    flag_next    = flag_reg;
`endif

    case (state_reg)
      IDLE: begin
        color_next = color_reg + 2'd1;
        if (fall)
          state_next = LEAD;
      end
      LEAD: begin
        if (rise)
          state_next = (cnt_reg >= LEAD_M) ? GAP : IDLE;
        else if (sat)
          state_next = ERR;
      end
      GAP: begin
        if (fall) begin
          if (cnt_reg >= GAP_M) begin
            state_next = MARK;
            idx_next   = '0;
          end
`ifdef IR_REPEAT_EN
          else if (cnt_reg >= REP_M)
            state_next = REPEAT;
`endif
          else
            state_next = ERR;
        end else if (sat) begin
          state_next = ERR;
        end
      end
      MARK: begin
        if (rise)
          state_next = SPACE;
        else if (sat)
          state_next = ERR;
      end
      SPACE: begin
        if (fall) begin
          shift_next = shift_in;
          if (idx_reg == IDX_LAST) begin
            state_next   = DONE;
            code_next    = lookup_code;
            key_next     = key_sel;
            valid_next   = 1'b1;
            rdy_next     = 1'b1;
            rdy_cnt_next = RDY_LOAD;
`ifdef IR_REPEAT_EN
            flag_next    = 1'b1;
`endif
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = MARK;
          end
        end else if (sat) begin
          state_next = ERR;
        end
      end
`ifdef IR_REPEAT_EN
      REPEAT: begin
        if (rise) begin
          if (flag_reg) begin
            state_next   = DONE;
            key_next     = key_sel;
            valid_next   = 1'b1;
            rdy_next     = 1'b1;
            rdy_cnt_next = RDY_LOAD;
          end else begin
            state_next = ERR;
          end
        end else if (sat) begin
          state_next = ERR;
        end
      end
`endif
      DONE, HOLD: begin
        if (rdy_cnt_reg == '0) begin
          state_next = IDLE;
          rdy_next   = 1'b0;
        end else begin
          rdy_cnt_next = rdy_cnt_reg - RC_W'(1);
          state_next   = HOLD;
        end
      end
      ERR: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next == ERR && state_reg != ERR)
      err_next = 1'b1;
  end

  assign code  = code_reg;
  assign key   = key_reg;
  assign valid = valid_reg;
  assign rdy   = rdy_reg;
  assign err   = err_reg;
  assign color = color_reg;

endmodule
